// File: rtl/rmt_pkg.sv
// Shared RMT pipeline definitions: PHV container geometry and buffer state encoding.
package rmt_pkg;
   localparam int NUM_CONT    = 8;
   localparam int C48_W       = 48;
   localparam int C32_W       = 32;
   localparam int C16_W       = 16;
   localparam int CA_W        = 20;
   localparam int CA_NUM      = 5;
   localparam int PAD_W       = 256;
   localparam int PKT_HDR_LEN = NUM_CONT * (C48_W + C32_W + C16_W) + CA_NUM * CA_W + PAD_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_FULL   = 2'd2
   } buf_state_t;
endpackage

// File: rtl/phv_buf_mem.sv
// PHV storage: simple dual-port, synchronous write, asynchronous read (distributed RAM).
module phv_buf_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = rmt_pkg::PKT_HDR_LEN,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);
   import rmt_pkg::*;

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/phv_buffer.sv
// Absorbs single-cycle PHV pulses from the parser and re-presents them to the first
// match-action stage over valid/ready, with occupancy, throttle and drop statistics.
module phv_buffer #(
   parameter int PKT_HDR_LEN  = rmt_pkg::PKT_HDR_LEN,
   parameter int DEPTH        = 4,
   parameter int AFULL_MARGIN = 1,
   parameter int CNT_W        = 32
) (
   input  logic                     axis_clk,
   input  logic                     areset,
   input  logic                     phv_valid_in,
   input  logic [PKT_HDR_LEN-1:0]   phv_in,
   output logic                     m_phv_valid,
   output logic [PKT_HDR_LEN-1:0]   m_phv_out,
   input  logic                     m_phv_ready,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   high_water,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic                     overflow,
   input  logic                     stats_clr
);
   import rmt_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0]    DEPTH_C  = PW'(DEPTH);
   localparam logic [PW-1:0]    AFULL_TH = PW'(DEPTH - AFULL_MARGIN);
   localparam logic [CNT_W-1:0] DROP_MAX = '1;

   logic [PW-1:0]          r_wr_ptr, r_rd_ptr, r_count, r_hw;
   logic [CNT_W-1:0]       r_drop_cnt;
   logic                   r_valid, r_afull, r_ovf;
   buf_state_t             r_state;
   logic [PW-1:0]          w_cnt_nxt;
   logic                   w_full, w_pop, w_push, w_drop;
   logic [PKT_HDR_LEN-1:0] w_rd_data;

   // Pointer MSB is the wrap bit: same index with differing wrap means full.
   assign w_full = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_pop  = r_valid & m_phv_ready;
   assign w_push = phv_valid_in & (~w_full | w_pop);
   assign w_drop = phv_valid_in & w_full & ~w_pop;

   always_comb begin
      w_cnt_nxt = r_count;
      if (w_push && !w_pop)      w_cnt_nxt = r_count + 1'b1;
      else if (w_pop && !w_push) w_cnt_nxt = r_count - 1'b1;
   end

   phv_buf_mem #(
      .DEPTH (DEPTH),
      .WIDTH (PKT_HDR_LEN)
   ) u_mem (
      .clk       (axis_clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_data (phv_in),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge axis_clk or posedge areset) begin
      if (areset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_cnt_nxt;
      end
   end

   // Occupancy state plus the registered handshake/throttle outputs, all from next-count.
   always_ff @(posedge axis_clk or posedge areset) begin
      if (areset) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_afull <= 1'b0;
      end else begin
         r_valid <= (w_cnt_nxt != '0);
         r_afull <= (w_cnt_nxt >= AFULL_TH);
         case (r_state)
            S_IDLE:   if (w_push) r_state <= S_ACTIVE;
            S_ACTIVE: begin
               if (w_push && !w_pop && (r_count == DEPTH_C - 1'b1)) r_state <= S_FULL;
               else if (w_pop && !w_push && (r_count == PW'(1)))   r_state <= S_IDLE;
            end
            S_FULL:   if (w_pop && !w_push) r_state <= S_ACTIVE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // Clear wins over a coincident drop; high-water reloads from next-count, not zero.
   always_ff @(posedge axis_clk or posedge areset) begin
      if (areset) begin
         r_hw       <= '0;
         r_drop_cnt <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_ovf <= w_drop;
         if (stats_clr) begin
            r_hw       <= w_cnt_nxt;
            r_drop_cnt <= '0;
         end else begin
            if (w_cnt_nxt > r_hw) r_hw <= w_cnt_nxt;
            if (w_drop && (r_drop_cnt != DROP_MAX)) r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   assign m_phv_valid = r_valid;
   assign m_phv_out   = r_valid ? w_rd_data : '0;
   assign almost_full = r_afull;
   assign count       = r_count;
   assign high_water  = r_hw;
   assign drop_cnt    = r_drop_cnt;
   assign overflow    = r_ovf;
endmodule

// File: tb/tb_phv_buffer.sv
// Bench for phv_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_phv_buffer;
   localparam int W     = 1124;
   localparam int DEPTH = 4;
   localparam int AFM   = 1;
   localparam int CNT_W = 4;
   localparam int DMAX  = (1 << CNT_W) - 1;

   logic          axis_clk = 1'b0;
   logic          areset;
   logic          phv_valid_in;
   logic [W-1:0]  phv_in;
   logic          m_phv_valid;
   logic [W-1:0]  m_phv_out;
   logic          m_phv_ready;
   logic          almost_full;
   logic [2:0]    count;
   logic [2:0]    high_water;
   logic [CNT_W-1:0] drop_cnt;
   logic          overflow;
   logic          stats_clr;

   phv_buffer #(
      .PKT_HDR_LEN  (W),
      .DEPTH        (DEPTH),
      .AFULL_MARGIN (AFM),
      .CNT_W        (CNT_W)
   ) dut (
      .axis_clk     (axis_clk),
      .areset       (areset),
      .phv_valid_in (phv_valid_in),
      .phv_in       (phv_in),
      .m_phv_valid  (m_phv_valid),
      .m_phv_out    (m_phv_out),
      .m_phv_ready  (m_phv_ready),
      .almost_full  (almost_full),
      .count        (count),
      .high_water   (high_water),
      .drop_cnt     (drop_cnt),
      .overflow     (overflow),
      .stats_clr    (stats_clr)
   );

   always #5 axis_clk = ~axis_clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] q[$];
   int m_hw, m_drop;
   bit m_ovf;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (low 64b) t=%0t", tag, obs[63:0], exp[63:0], $time);
      end
   endtask

   function automatic logic [W-1:0] rnd_phv();
      logic [W-1:0] v = '0;
      for (int i = 0; i < 36; i++) v = (v << 32) | W'($urandom);
      return v;
   endfunction

   task automatic check_outputs(input string pfx);
      int sz = q.size();
      chk({pfx, "_valid"}, W'(m_phv_valid), W'(sz != 0));
      chk({pfx, "_data"},  m_phv_out, (sz != 0) ? q[0] : '0);
      chk({pfx, "_count"}, W'(count), W'(sz));
      chk({pfx, "_afull"}, W'(almost_full), W'(sz >= DEPTH - AFM));
      chk({pfx, "_hwater"}, W'(high_water), W'(m_hw));
      chk({pfx, "_drops"}, W'(drop_cnt), W'(m_drop));
      chk({pfx, "_ovf"},   W'(overflow), W'(m_ovf));
   endtask

   // One clock: drive, check pre-edge outputs, advance the model, take the edge.
   task automatic cycle(input string pfx, input bit v, input logic [W-1:0] d, input bit rdy, input bit clr);
      bit pop, push, drop, full;
      phv_valid_in = v;
      phv_in       = d;
      m_phv_ready  = rdy;
      stats_clr    = clr;
      @(negedge axis_clk);
      check_outputs(pfx);
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && rdy;
      push = v && (!full || pop);
      drop = v && full && !pop;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
      m_ovf = drop;
      if (clr) begin
         m_drop = 0;
         m_hw   = q.size();
      end else begin
         if (drop && m_drop < DMAX) m_drop++;
         if (q.size() > m_hw) m_hw = q.size();
      end
      @(posedge axis_clk);
      #1;
   endtask

   task automatic reset_model();
      q.delete();
      m_hw = 0; m_drop = 0; m_ovf = 0;
   endtask

   logic [W-1:0] pat, p[5];

   initial begin
      reset_model();
      areset = 1'b1; phv_valid_in = 1'b0; phv_in = '0; m_phv_ready = 1'b0; stats_clr = 1'b0;
      repeat (3) @(posedge axis_clk);
      #1;
      check_outputs("rst");
      @(negedge axis_clk);
      areset = 1'b0;
      @(posedge axis_clk);
      #1;
      repeat (2) cycle("idle", 0, '0, 1, 0);

      pat = '0;
      for (int i = 0; i < 141; i++) pat = (pat << 8) | W'(8'hA5);
      cycle("single", 1, pat, 1, 0);
      repeat (2) cycle("single", 0, '0, 1, 0);

      for (int i = 0; i < 5; i++) p[i] = rnd_phv();
      for (int i = 0; i < 4; i++) cycle("fill", 1, p[i], 0, 0);
      for (int i = 0; i < 3; i++) cycle("ovf", 1, rnd_phv(), 0, 0);
      cycle("ovf", 0, '0, 0, 1);
      cycle("clr", 1, p[4], 1, 0);
      repeat (6) cycle("drain", 0, '0, 1, 0);

      for (int i = 0; i < 4; i++) cycle("sfill", 1, rnd_phv(), 0, 0);
      for (int i = 0; i < 20; i++) cycle("sat", 1, rnd_phv(), 0, 0);
      cycle("sat", 0, '0, 0, 1);
      repeat (5) cycle("sdrain", 0, '0, 1, 0);

      for (int i = 0; i < 10; i++) cycle("wrap", 1, rnd_phv(), 1, 0);
      repeat (2) cycle("wrap", 0, '0, 1, 0);

      for (int i = 0; i < 800; i++) begin
         int thr = (i / 200) + 1;
         cycle("rand", ($urandom % 3) != 0, rnd_phv(), ($urandom % 5) < thr, ($urandom % 64) == 0);
      end
      repeat (6) cycle("rdrain", 0, '0, 1, 0);

      for (int i = 0; i < 3; i++) cycle("prerst", 1, rnd_phv(), 0, 0);
      phv_valid_in = 1'b0; m_phv_ready = 1'b0;
      #3;
      areset = 1'b1;
      #1;
      reset_model();
      check_outputs("midrst");
      @(posedge axis_clk);
      @(negedge axis_clk);
      areset = 1'b0;
      @(posedge axis_clk);
      #1;
      repeat (2) cycle("postrst", 0, '0, 1, 0);
      cycle("postrst", 1, pat ^ p[0], 1, 0);
      repeat (2) cycle("postrst", 0, '0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/phv_buffer.md
Name: phv_buffer

Overview:
- Downstream neighbour of the parser stage.
- Captures each single-cycle PHV pulse from the parser into a small circular buffer.
- Presents PHVs to the first match-action stage over a valid/ready handshake, because the parser itself has no backpressure.
- Provides occupancy, almost-full (for upstream ingress throttling), drop and high-water statistics.

Parameters:
- PKT_HDR_LEN, 1124, PHV width: 8x48b + 8x32b + 8x16b containers, 5x20b condition actions, 256b pad.
- DEPTH, 4, number of PHV entries; power of two, at least 2.
- AFULL_MARGIN, 1, almost_full asserts when count >= DEPTH - AFULL_MARGIN.
- CNT_W, 32, width of the drop counter.

Ports:
- axis_clk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- phv_valid_in  in  1  one-cycle pulse from the parser, one per packet.
- phv_in  in  PKT_HDR_LEN  PHV from the parser; sampled when phv_valid_in=1.
- m_phv_valid  out  1  head entry available.
- m_phv_out  out  PKT_HDR_LEN  head PHV; forced to 0 when m_phv_valid=0.
- m_phv_ready  in  1  downstream accepts the head entry.
- almost_full  out  1  registered throttle hint to ingress.
- count  out  clog2(DEPTH)+1  current occupancy.
- high_water  out  clog2(DEPTH)+1  maximum occupancy since reset or clear.
- drop_cnt  out  CNT_W  PHVs discarded because the buffer was full.
- overflow  out  1  one-cycle pulse on each drop.
- stats_clr  in  1  synchronous clear of drop_cnt and high_water.

Behaviour:
- Reset (areset=1, asynchronous):
  - wr_ptr, rd_ptr and count = 0.
  - m_phv_valid=0, m_phv_out=0, almost_full=0, high_water=0, drop_cnt=0, overflow=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all buffered PHVs; nothing is emitted after reset deasserts until a new push.
- Pointers are clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
  - Both pointers wrap from DEPTH-1 to 0, toggling the wrap bit.
- pop = m_phv_valid & m_phv_ready; rd_ptr advances on the clock edge.
- push = phv_valid_in & (~full | pop).
  - When full, a push is still accepted if a pop occurs in the same cycle.
  - On push: mem[wr_ptr] <= phv_in and wr_ptr advances.
- drop = phv_valid_in & full & ~pop.
  - The PHV is discarded and overflow pulses for 1 cycle after the edge.
  - drop_cnt increments and saturates at 2^CNT_W-1; it never wraps.
- count next value:
  - count+1 on push only.
  - count-1 on pop only.
  - unchanged on both or neither.
- State machine: IDLE, ACTIVE, FULL, derived from count (0, 1..DEPTH-1, DEPTH).
  - Transitions follow the count rules above.
  - A transition from IDLE directly to FULL is impossible, because there is at most one push per cycle.
- Latency: a PHV pushed at edge k appears on m_phv_out with m_phv_valid=1 from edge k+1.
  - A PHV pushed into an empty buffer is visible the next cycle.
- m_phv_valid = (count != 0) and is registered.
  - m_phv_out = mem[rd_ptr] gated by m_phv_valid.
  - m_phv_out stays stable while m_phv_valid=1 and m_phv_ready=0.
- almost_full is registered from next-count, so it is valid in the same cycle count updates.
- high_water <= max(high_water, next count).
- stats_clr:
  - Clears drop_cnt and high_water at the edge; clear wins over a coincident drop or increment.
  - On that edge, high_water loads the current next-count, not 0.
  - Does not affect buffered data, pointers or count.
- phv_in is taken verbatim. Container order and the condition-action field are not interpreted.

Decomposition:
- Shared package rmt_pkg holds:
  - PKT_HDR_LEN.
  - Container counts and widths (8 per class; 48/32/16 bits).
  - Condition-action width (20) and count (5).
  - Pad width (256).
- Sub-module phv_buf_mem: simple dual-port, DEPTH x PKT_HDR_LEN, synchronous write, asynchronous read (distributed RAM).
- Pointer, count, state and statistics logic stays in phv_buffer.

Test Plan:
- Single push, DEPTH=4, ready=1:
  - Stimulus: phv_in=0xA5 pattern pulsed at edge 10.
  - Response: m_phv_valid=1 with m_phv_out=0xA5 pattern in cycle 11; popped at edge 11; count returns to 0; high_water=1.
- Fill with ready=0, DEPTH=4, AFULL_MARGIN=1:
  - Stimulus: 4 pushes P1..P4.
  - Response: almost_full=1 after P3; count=4; m_phv_out=P1 throughout.
  - Then raise ready: P1..P4 are emitted in order on 4 consecutive cycles.
- Overflow with count=4 and ready=0:
  - Stimulus: 3 more pulses.
  - Response: each pulse gives a 1-cycle overflow; drop_cnt=3; the buffer still holds P1..P4.
  - Then stats_clr: drop_cnt=0 and high_water=4.
- Full with simultaneous push and pop:
  - Stimulus: count=4, ready=1, push P5 in the same cycle.
  - Response: P1 pops; P5 is accepted; count stays 4; drop_cnt unchanged.
- Wrap-around:
  - Stimulus: 10 push/pop pairs through DEPTH=4.
  - Response: output order matches input order exactly; pointers wrap twice; no drops.
- Reset mid-operation:
  - Stimulus: count=3, assert areset asynchronously between edges.
  - Response: m_phv_valid, m_phv_out, count, almost_full, drop_cnt and high_water are 0 immediately.
  - After release, the first push gives valid one cycle later containing the new PHV only.
